memory_stage_ws: RTL and testbench
==================================

Name: memory_stage_ws

Overview:
Parametrised MEM stage for the five-stage pipeline: branch-condition resolution, data-memory access with a configurable number of wait states, and the MEM/WB pipeline latch in one block. This generation adds generic widths and depth, a valid qualifier, and a stall output that freezes the upstream stages while a multi-cycle memory access completes. It sits between the EX/MEM latch and the write-back stage.

Parameters:
DATA_W, 32, data and ALU-result width (multiple of 8)
ADDR_W, 8, word-address bits; memory depth = 2**ADDR_W words
RD_W, 4, destination-register index width
SIG_W, 11, control-signal bundle width
COND_W, 4, branch flag/condition width
WAIT_CYCLES, 2, extra cycles per load/store (0 = single-cycle)
BR_EN_BIT, 5, index of branch-enable in signals
MEM_WR_BIT, 6, index of memory-write in signals
MEM_RD_BIT, 7, index of memory-read in signals

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  EX/MEM holds a valid instruction
rd  in  RD_W  destination register
signals  in  SIG_W  control bundle
alu_branch  in  COND_W  ALU flags
control_branch  in  COND_W  branch condition mask
alu  in  DATA_W  ALU result / byte address
data_a  in  DATA_W  store data
stall  out  1  hold upstream stages and PC
pc_sel  out  1  branch taken, select branch target
out_valid  out  1  MEM/WB holds a valid instruction
rd_out  out  RD_W  latched rd
alu_out  out  DATA_W  latched ALU result
data_out  out  DATA_W  latched load data
sign_out  out  SIG_W  latched signals

Behaviour:
- Reset: state IDLE, wait counter 0, out_valid 0, rd_out/alu_out/data_out/sign_out 0, stall 0, pc_sel 0. Memory array is not reset.
- Word index = alu[ADDR_W+S-1:S], S = log2(DATA_W/8). Low S bits are ignored; upper bits beyond the index are ignored, so addresses wrap.
- Memory reads are combinational from the array. Writes commit on the clock edge.
- A memory operation is in_valid & (signals[MEM_RD_BIT] | signals[MEM_WR_BIT]).
- If both read and write are set, the write is performed and data_out = 0.
- FSM:
  - IDLE, no memory operation: latch inputs to the outputs next edge; out_valid = in_valid.
  - IDLE, memory operation with WAIT_CYCLES = 0: same single-cycle behaviour; the write commits on that edge and the load data is latched.
  - IDLE, memory operation with WAIT_CYCLES > 0: capture all inputs into holding registers, go to BUSY, set count = WAIT_CYCLES, set out_valid = 0.
  - BUSY: stall = 1 (combinational from state); count decrements each cycle. On the edge where count == 1, the write commits using the held address and data, outputs are latched from the holding registers plus the read data, out_valid = 1, and the FSM returns to IDLE.
  - Total latency for a memory operation is WAIT_CYCLES+1 cycles; stall is high for exactly WAIT_CYCLES cycles.
- Inputs are ignored while in BUSY; upstream holds them.
- pc_sel = in_valid & signals[BR_EN_BIT] & |(alu_branch & control_branch), evaluated only in IDLE. It is combinational and forced to 0 in BUSY, so it asserts exactly once per branch.
- out_valid = 0 forces nothing else; the data outputs keep their last value.
- Reset mid-BUSY aborts the access: a pending write is not committed, and the FSM returns to IDLE with the reset values above.
- Back-to-back memory operations: the second is accepted in the first IDLE cycle after return, with no bubble beyond that cycle.

Decomposition:
- Shared package mem_pkg holds the default widths, the signal-bit index constants, and the state encoding (IDLE=0, BUSY=1).
- One natural sub-module: data_mem_array, a parametrised DATA_W x 2**ADDR_W array with synchronous write and combinational read.
- Branch compare and FSM/latch logic stay in the top module.

Test Plan:
- Reset with rst=1 for 2 cycles mid-stream -> all outputs 0, stall=0; a store pending in BUSY does not change memory (read back the old value).
- Non-memory op: alu=0x1234, rd=3, in_valid=1 -> next cycle alu_out=0x1234, rd_out=3, out_valid=1, stall never asserted.
- Store then load, WAIT_CYCLES=2:
  - store data_a=0xDEADBEEF to alu=0x10 -> stall high 2 cycles, out_valid on the 3rd edge.
  - load from 0x10 -> data_out=0xDEADBEEF after 3 cycles.
- Branch: signals[5]=1, alu_branch=4'b0100, control_branch=4'b0110 -> pc_sel=1 for one cycle. With control_branch=4'b0011 -> pc_sel=0.
- Address wrap, ADDR_W=8: store 0xA5 at alu=0x400 -> load at alu=0x000 returns 0xA5.
- WAIT_CYCLES=0 build: load/store complete in 1 cycle, stall constantly 0. Read+write both set -> memory written, data_out=0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: default widths, control-bundle bit indices and FSM state encoding for the MEM stage
package mem_pkg;
  localparam int DATA_W_D = 32;
  localparam int ADDR_W_D = 8;
  localparam int RD_W_D = 4;
  localparam int SIG_W_D = 11;
  localparam int COND_W_D = 4;
  localparam int WAIT_CYCLES_D = 2;
  localparam int BR_EN_BIT_D = 5;
  localparam int MEM_WR_BIT_D = 6;
  localparam int MEM_RD_BIT_D = 7;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: DATA_W x 2**ADDR_W word memory; ports clk, we, addr, wdata (sync write), rdata (comb read)
module data_mem_array import mem_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/memory_stage_ws.sv
// memory_stage_ws: MEM stage with branch resolve, wait-stated data memory and MEM/WB latch; in: clk rst in_valid rd signals alu_branch control_branch alu data_a; out: stall pc_sel out_valid rd_out alu_out data_out sign_out
module memory_stage_ws import mem_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int RD_W = RD_W_D,
  parameter int SIG_W = SIG_W_D,
  parameter int COND_W = COND_W_D,
  parameter int WAIT_CYCLES = WAIT_CYCLES_D,
  parameter int BR_EN_BIT = BR_EN_BIT_D,
  parameter int MEM_WR_BIT = MEM_WR_BIT_D,
  parameter int MEM_RD_BIT = MEM_RD_BIT_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [RD_W-1:0]   rd,
  input  logic [SIG_W-1:0]  signals,
  input  logic [COND_W-1:0] alu_branch,
  input  logic [COND_W-1:0] control_branch,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] data_a,
  output logic              stall,
  output logic              pc_sel,
  output logic              out_valid,
  output logic [RD_W-1:0]   rd_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] data_out,
  output logic [SIG_W-1:0]  sign_out
);
  localparam int S = $clog2(DATA_W / 8);
  localparam int CNT_W = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [0:0] state;
  logic [CNT_W-1:0] count;
  logic [RD_W-1:0] h_rd, c_rd;
  logic [SIG_W-1:0] h_sig, c_sig;
  logic [DATA_W-1:0] h_alu, h_data, c_alu, c_data, rdata;
  logic busy, mem_op, done, accept, latch, we, unused_bits;
  always_comb begin
    busy = state == BUSY;
    mem_op = in_valid & (signals[MEM_RD_BIT] | signals[MEM_WR_BIT]);
    done = busy & (count == CNT_W'(1));
    accept = ~busy & mem_op & (WAIT_CYCLES != 0);
    latch = done | (~busy & ~accept);
    c_rd = busy ? h_rd : rd;
    c_sig = busy ? h_sig : signals;
    c_alu = busy ? h_alu : alu;
    c_data = busy ? h_data : data_a;
    we = ~rst & c_sig[MEM_WR_BIT] & (busy ? done : mem_op & (WAIT_CYCLES == 0));
    stall = busy;
    pc_sel = ~busy & in_valid & signals[BR_EN_BIT] & |(alu_branch & control_branch);
    unused_bits = ^c_alu;
  end
  data_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .we(we),
    .addr(c_alu[ADDR_W+S-1:S]),
    .wdata(c_data),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      out_valid <= 1'b0;
      rd_out <= '0;
      alu_out <= '0;
      data_out <= '0;
      sign_out <= '0;
    end else begin
      if (busy) count <= count - 1'b1;
      if (done) state <= IDLE;
      if (latch) begin
        out_valid <= busy | in_valid;
        rd_out <= c_rd;
        alu_out <= c_alu;
        sign_out <= c_sig;
        data_out <= (c_sig[MEM_RD_BIT] & ~c_sig[MEM_WR_BIT]) ? rdata : '0;
      end
      if (accept) begin
        state <= BUSY;
        count <= CNT_W'(WAIT_CYCLES);
        out_valid <= 1'b0;
        h_rd <= rd;
        h_sig <= signals;
        h_alu <= alu;
        h_data <= data_a;
      end
    end
  end
endmodule

// File: tb/tb_memory_stage_ws.sv
// tb_memory_stage_ws: vector table plus scoreboard check of memory_stage_ws at WAIT_CYCLES=2 and 0
module tb_memory_stage_ws;
  typedef struct {
    logic [3:0]  rd;
    logic [10:0] sig;
    logic [3:0]  ab;
    logic [3:0]  cb;
    logic [31:0] alu;
    logic [31:0] da;
    logic        pc;
    int          st;
    logic [31:0] dat;
  } vec_t;
  typedef struct {
    logic [3:0]  rd;
    logic [31:0] alu;
    logic [10:0] sig;
    logic [31:0] dat;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0;
  logic [3:0] rd = '0, alu_branch = '0, control_branch = '0;
  logic [10:0] signals = '0;
  logic [31:0] alu = '0, data_a = '0;
  logic stall, pc_sel, out_valid;
  logic [3:0] rd_out;
  logic [31:0] alu_out, data_out;
  logic [10:0] sign_out;
  logic v0 = 1'b0;
  logic [3:0] rd0 = '0, ab0 = '0, cb0 = '0;
  logic [10:0] sig0 = '0;
  logic [31:0] alu0 = '0, da0 = '0;
  logic stall0, pc0, ov0;
  logic [3:0] rdo0;
  logic [31:0] alo0, do0;
  logic [10:0] so0;
  logic stall0_seen = 1'b0;
  int tests = 0, fails = 0;
  exp_t sb[$];
  vec_t vecs[14];
  always #5 clk = ~clk;
  memory_stage_ws #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rd(rd), .signals(signals),
    .alu_branch(alu_branch), .control_branch(control_branch), .alu(alu), .data_a(data_a),
    .stall(stall), .pc_sel(pc_sel), .out_valid(out_valid), .rd_out(rd_out),
    .alu_out(alu_out), .data_out(data_out), .sign_out(sign_out)
  );
  memory_stage_ws #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .rd(rd0), .signals(sig0),
    .alu_branch(ab0), .control_branch(cb0), .alu(alu0), .data_a(da0),
    .stall(stall0), .pc_sel(pc0), .out_valid(ov0), .rd_out(rdo0),
    .alu_out(alo0), .data_out(do0), .sign_out(so0)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (stall0 === 1'b1) stall0_seen = 1'b1;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got 1 expected 0");
      end else begin
        e = sb.pop_front();
        chk("rd_out", 32'(rd_out), 32'(e.rd));
        chk("alu_out", alu_out, e.alu);
        chk("sign_out", 32'(sign_out), 32'(e.sig));
        chk("data_out", data_out, e.dat);
      end
    end
  end
  task automatic issue(input vec_t v);
    int n;
    @(negedge clk);
    in_valid = 1'b1; rd = v.rd; signals = v.sig; alu_branch = v.ab;
    control_branch = v.cb; alu = v.alu; data_a = v.da;
    #1 chk("pc_sel", 32'(pc_sel), 32'(v.pc));
    sb.push_back('{v.rd, v.alu, v.sig, v.dat});
    @(posedge clk); #1;
    n = 0;
    while (stall && n < 10) begin
      chk("pc_sel_busy", 32'(pc_sel), 32'h0);
      n++;
      @(posedge clk); #1;
    end
    chk("stall_cycles", 32'(n), 32'(v.st));
    in_valid = 1'b0;
  endtask
  task automatic step0(input logic [10:0] s, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    v0 = 1'b1; rd0 = 4'h9; sig0 = s; alu0 = a; da0 = d;
    @(posedge clk); #1;
    v0 = 1'b0;
    chk("w0_out_valid", 32'(ov0), 32'h1);
    chk("w0_alu_out", alo0, a);
  endtask
  task automatic chk_reset();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_pc_sel", 32'(pc_sel), 32'h0);
    chk("rst_rd_out", 32'(rd_out), 32'h0);
    chk("rst_alu_out", alu_out, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_sign_out", 32'(sign_out), 32'h0);
  endtask
  initial begin
    vecs[0]  = '{4'h3, 11'h000, 4'h0, 4'h0, 32'h0000_1234, 32'h0, 1'b0, 0, 32'h0};
    vecs[1]  = '{4'h1, 11'h040, 4'h0, 4'h0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 2, 32'h0};
    vecs[2]  = '{4'h2, 11'h080, 4'h0, 4'h0, 32'h0000_0010, 32'h0, 1'b0, 2, 32'hDEAD_BEEF};
    vecs[3]  = '{4'h4, 11'h020, 4'b0100, 4'b0110, 32'h0000_0040, 32'h0, 1'b1, 0, 32'h0};
    vecs[4]  = '{4'h5, 11'h020, 4'b0100, 4'b0011, 32'h0000_0040, 32'h0, 1'b0, 0, 32'h0};
    vecs[5]  = '{4'h6, 11'h040, 4'h0, 4'h0, 32'h0000_0400, 32'h0000_00A5, 1'b0, 2, 32'h0};
    vecs[6]  = '{4'h7, 11'h080, 4'h0, 4'h0, 32'h0000_0000, 32'h0, 1'b0, 2, 32'h0000_00A5};
    vecs[7]  = '{4'h8, 11'h040, 4'h0, 4'h0, 32'h0000_0013, 32'h1122_3344, 1'b0, 2, 32'h0};
    vecs[8]  = '{4'h9, 11'h080, 4'h0, 4'h0, 32'h0000_0010, 32'h0, 1'b0, 2, 32'h1122_3344};
    vecs[9]  = '{4'hA, 11'h0C0, 4'h0, 4'h0, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 2, 32'h0};
    vecs[10] = '{4'hB, 11'h080, 4'h0, 4'h0, 32'h0000_0020, 32'h0, 1'b0, 2, 32'hCAFE_F00D};
    vecs[11] = '{4'hC, 11'h000, 4'hF, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, 32'h0};
    vecs[12] = '{4'hD, 11'h0A0, 4'h1, 4'h1, 32'h0000_0400, 32'h0, 1'b1, 2, 32'h0000_00A5};
    vecs[13] = '{4'hE, 11'h03F, 4'h8, 4'h8, 32'hAAAA_5555, 32'h0, 1'b1, 0, 32'h0};
    repeat (2) @(posedge clk);
    #1 chk_reset();
    chk("rst_w0_out_valid", 32'(ov0), 32'h0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 14; i++) issue(vecs[i]);
    @(negedge clk);
    in_valid = 1'b1; rd = 4'h1; signals = 11'h040; alu = 32'h10; data_a = 32'h5555_5555;
    alu_branch = '0; control_branch = '0;
    @(posedge clk); #1 chk("abort_stall0", 32'(stall), 32'h1);
    @(posedge clk); #1 chk("abort_stall1", 32'(stall), 32'h1);
    @(negedge clk) begin rst = 1'b1; in_valid = 1'b0; end
    repeat (2) @(posedge clk);
    #1 chk_reset();
    @(negedge clk) rst = 1'b0;
    issue('{4'h2, 11'h080, 4'h0, 4'h0, 32'h0000_0010, 32'h0, 1'b0, 2, 32'h1122_3344});
    step0(11'h040, 32'h80, 32'h1234_5678);
    step0(11'h080, 32'h80, 32'h0);
    chk("w0_load", do0, 32'h1234_5678);
    step0(11'h0C0, 32'h84, 32'h0BAD_C0DE);
    chk("w0_rdwr_data", do0, 32'h0);
    step0(11'h080, 32'h84, 32'h0);
    chk("w0_rdwr_mem", do0, 32'h0BAD_C0DE);
    repeat (2) @(posedge clk);
    #1 chk("sb_empty", 32'(sb.size()), 32'h0);
    chk("w0_stall_never", 32'(stall0_seen), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
